// File: rtl/i2s_rxram_frame_seq.sv
// i2s_rxram_frame_seq: streams one frame from the Rx ping-pong RAM bank to the decimating
// filter engine and writes the engine results back into the same bank; yields to Wishbone.
module i2s_rxram_frame_seq #(
   parameter int FRAME_LEN = 512,
   parameter int DEC_RATIO = 4,
   parameter int RES_BASE  = 512
) (
   input  logic        WBs_CLK_i,
   input  logic        WBs_RST_n_i,
   input  logic        f_start_i,
   input  logic        wb_mast_sel_i,
   input  logic        clr_status_i,
   output logic [9:0]  ram_raddr_o,
   input  logic [15:0] ram_rd_data_i,
   output logic [9:0]  ram_waddr_o,
   output logic [15:0] ram_wr_data_o,
   output logic        ram_wr_en_o,
   output logic        smp_valid_o,
   output logic [15:0] smp_data_o,
   output logic        smp_last_o,
   input  logic        smp_ready_i,
   input  logic        res_valid_i,
   input  logic [15:0] res_data_i,
   output logic        res_ready_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        overrun_o,
   output logic        abort_o,
   output logic [7:0]  ovr_cnt_o
);
   localparam logic [10:0] FRAME_N = 11'(FRAME_LEN);
   localparam logic [10:0] RES_N   = 11'(FRAME_LEN / DEC_RATIO);
   localparam logic [9:0]  LAST    = 10'(FRAME_LEN - 1);
   localparam logic [9:0]  BASE    = 10'(RES_BASE);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, SEND, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [9:0]  rd_cnt_q, rd_cnt_d;
   logic [10:0] smp_cnt_q, smp_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [15:0] smp_data_q, smp_data_d, wdata_q, wdata_d;
   logic [9:0]  waddr_q, waddr_d;
   logic        smp_valid_q, smp_valid_d, smp_last_q, smp_last_d;
   logic        wen_q, wen_d, done_q, done_d, ovr_q, ovr_d, abort_q, abort_d;
   logic [7:0]  ovr_cnt_q, ovr_cnt_d;
   logic        busy, res_rdy, res_hs, abort_ev, ovr_ev;

   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) begin
         state_q     <= IDLE;
         rd_cnt_q    <= '0;
         smp_cnt_q   <= '0;
         wr_cnt_q    <= '0;
         smp_data_q  <= '0;
         smp_valid_q <= 1'b0;
         smp_last_q  <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         wen_q       <= 1'b0;
         done_q      <= 1'b0;
         ovr_q       <= 1'b0;
         abort_q     <= 1'b0;
         ovr_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         rd_cnt_q    <= rd_cnt_d;
         smp_cnt_q   <= smp_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         smp_data_q  <= smp_data_d;
         smp_valid_q <= smp_valid_d;
         smp_last_q  <= smp_last_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         wen_q       <= wen_d;
         done_q      <= done_d;
         ovr_q       <= ovr_d;
         abort_q     <= abort_d;
         ovr_cnt_q   <= ovr_cnt_d;
      end
   end

   always_comb begin
      busy        = state_q != IDLE;
      res_rdy     = busy && wr_cnt_q < RES_N;
      res_hs      = res_valid_i && res_rdy;
      abort_ev    = busy && wb_mast_sel_i;
      ovr_ev      = f_start_i && (busy || wb_mast_sel_i);
      state_d     = state_q;
      rd_cnt_d    = rd_cnt_q;
      smp_cnt_d   = smp_cnt_q;
      wr_cnt_d    = res_hs ? wr_cnt_q + 11'd1 : wr_cnt_q;
      smp_data_d  = smp_data_q;
      smp_valid_d = smp_valid_q;
      smp_last_d  = smp_last_q;
      wen_d       = res_hs;
      waddr_d     = res_hs ? BASE + wr_cnt_q[9:0] : waddr_q;
      wdata_d     = res_hs ? res_data_i : wdata_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: if (f_start_i && !wb_mast_sel_i) begin
            state_d   = RD_ADDR;
            rd_cnt_d  = '0;
            smp_cnt_d = '0;
            wr_cnt_d  = '0;
         end
         RD_ADDR: state_d = RD_WAIT;
         RD_WAIT: begin
            smp_data_d  = ram_rd_data_i;
            smp_valid_d = 1'b1;
            smp_last_d  = rd_cnt_q == LAST;
            state_d     = SEND;
         end
         SEND: if (smp_ready_i) begin
            smp_valid_d = 1'b0;
            smp_last_d  = 1'b0;
            rd_cnt_d    = rd_cnt_q + 10'd1;
            smp_cnt_d   = smp_cnt_q + 11'd1;
            state_d     = (smp_cnt_q + 11'd1 < FRAME_N) ? RD_ADDR : DRAIN;
         end
         DRAIN: if (wr_cnt_q == RES_N) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Wishbone takeover wins over everything, including a result captured this cycle
      if (abort_ev) begin
         state_d     = IDLE;
         smp_valid_d = 1'b0;
         smp_last_d  = 1'b0;
         wen_d       = 1'b0;
         done_d      = 1'b0;
      end
      ovr_d     = ovr_ev || (ovr_q && !clr_status_i);
      abort_d   = abort_ev || (abort_q && !clr_status_i);
      ovr_cnt_d = clr_status_i ? {7'd0, ovr_ev} :
                  (ovr_ev && ovr_cnt_q != 8'hFF) ? ovr_cnt_q + 8'd1 : ovr_cnt_q;
   end

   assign ram_raddr_o   = rd_cnt_q;
   assign ram_waddr_o   = waddr_q;
   assign ram_wr_data_o = wdata_q;
   assign ram_wr_en_o   = wen_q;
   assign smp_valid_o   = smp_valid_q;
   assign smp_data_o    = smp_data_q;
   assign smp_last_o    = smp_last_q;
   assign res_ready_o   = res_rdy;
   assign busy_o        = busy;
   assign done_o        = done_q;
   assign overrun_o     = ovr_q;
   assign abort_o       = abort_q;
   assign ovr_cnt_o     = ovr_cnt_q;
endmodule

// File: tb/tb_i2s_rxram_frame_seq.sv
// tb_i2s_rxram_frame_seq: directed bench with a RAM model and a 4:1 engine stand-in.
module tb_i2s_rxram_frame_seq;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        f_start_i = 1'b0, wb_mast_sel_i = 1'b0, clr_status_i = 1'b0;
   logic        smp_ready_i = 1'b0, res_valid_i = 1'b0;
   logic [15:0] res_data_i = '0, ram_rd_data_i = '0;
   logic [9:0]  ram_raddr_o, ram_waddr_o;
   logic [15:0] ram_wr_data_o, smp_data_o;
   logic        ram_wr_en_o, smp_valid_o, smp_last_o, res_ready_o;
   logic        busy_o, done_o, overrun_o, abort_o;
   logic [7:0]  ovr_cnt_o;
   logic [15:0] mem [1024];

   int total = 0, bad = 0;
   int acc_idx, res_idx, wr_idx, done_cnt, last_cnt, wr_mark;
   logic        hold_pending = 1'b0;
   logic [15:0] hold_data = '0;

   i2s_rxram_frame_seq dut (
      .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .f_start_i(f_start_i),
      .wb_mast_sel_i(wb_mast_sel_i), .clr_status_i(clr_status_i),
      .ram_raddr_o(ram_raddr_o), .ram_rd_data_i(ram_rd_data_i),
      .ram_waddr_o(ram_waddr_o), .ram_wr_data_o(ram_wr_data_o), .ram_wr_en_o(ram_wr_en_o),
      .smp_valid_o(smp_valid_o), .smp_data_o(smp_data_o), .smp_last_o(smp_last_o),
      .smp_ready_i(smp_ready_i), .res_valid_i(res_valid_i), .res_data_i(res_data_i),
      .res_ready_o(res_ready_o), .busy_o(busy_o), .done_o(done_o),
      .overrun_o(overrun_o), .abort_o(abort_o), .ovr_cnt_o(ovr_cnt_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ram_rd_data_i <= mem[ram_raddr_o];
      if (ram_wr_en_o) mem[ram_waddr_o] <= ram_wr_data_o;
   end

   function automatic logic [15:0] pattern(input int i);
      return 16'(i * 947 + 16'h1234);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit rnd);
      @(negedge clk);
      if (ram_wr_en_o) begin
         chk("wr_addr", 32'(ram_waddr_o), 32'(512 + wr_idx));
         chk("wr_data", 32'(ram_wr_data_o), 32'(16'hA000 + wr_idx));
         wr_idx++;
      end
      if (done_o) done_cnt++;
      if (hold_pending && smp_valid_o) chk("hold", 32'(smp_data_o), 32'(hold_data));
      smp_ready_i = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (smp_valid_o && smp_ready_i) begin
         chk("smp_data", 32'(smp_data_o), 32'(pattern(acc_idx)));
         chk("smp_last", 32'(smp_last_o), 32'(acc_idx == 511));
         if (smp_last_o) last_cnt++;
         acc_idx++;
         hold_pending = 1'b0;
      end else begin
         hold_pending = smp_valid_o;
         hold_data = smp_data_o;
      end
      res_valid_i = (acc_idx / 4) > res_idx;
      res_data_i = 16'(16'hA000 + res_idx);
      if (res_valid_i && res_ready_o) res_idx++;
   endtask

   task automatic start_frame();
      acc_idx = 0; res_idx = 0; wr_idx = 0; done_cnt = 0; last_cnt = 0;
      hold_pending = 1'b0;
      f_start_i = 1'b1;
      step(1'b0);
      f_start_i = 1'b0;
   endtask

   task automatic finish_frame(input bit rnd, input string tag);
      for (int i = 0; i < 8000 && done_cnt == 0; i++) step(rnd);
      chk({tag, "_done"}, 32'(done_cnt), 32'd1);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_samples"}, 32'(acc_idx), 32'd512);
      chk({tag, "_last_cnt"}, 32'(last_cnt), 32'd1);
      chk({tag, "_writes"}, 32'(wr_idx), 32'd128);
      for (int i = 0; i < 5; i++) step(rnd);
      chk({tag, "_one_done"}, 32'(done_cnt), 32'd1);
      chk({tag, "_no_extra_wr"}, 32'(wr_idx), 32'd128);
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_raddr"}, 32'(ram_raddr_o), 32'd0);
      chk({tag, "_waddr"}, 32'(ram_waddr_o), 32'd0);
      chk({tag, "_wdata"}, 32'(ram_wr_data_o), 32'd0);
      chk({tag, "_wen"}, 32'(ram_wr_en_o), 32'd0);
      chk({tag, "_valid"}, 32'(smp_valid_o), 32'd0);
      chk({tag, "_data"}, 32'(smp_data_o), 32'd0);
      chk({tag, "_last"}, 32'(smp_last_o), 32'd0);
      chk({tag, "_res_ready"}, 32'(res_ready_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_overrun"}, 32'(overrun_o), 32'd0);
      chk({tag, "_abort"}, 32'(abort_o), 32'd0);
      chk({tag, "_ovr_cnt"}, 32'(ovr_cnt_o), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = pattern(i);
      #3;
      all_zero("reset");
      #20 rst_n = 1'b1;

      // nominal frame with an always-ready engine
      start_frame();
      finish_frame(1'b0, "nominal");
      chk("mem_res0", 32'(mem[512]), 32'hA000);
      chk("mem_res1", 32'(mem[513]), 32'hA001);
      chk("mem_res127", 32'(mem[639]), 32'hA07F);
      chk("mem_beyond", 32'(mem[640]), 32'(pattern(640)));

      // 30% ready duty backpressure
      start_frame();
      finish_frame(1'b1, "backpr");

      // overrun mid-frame does not disturb the running frame
      start_frame();
      for (int i = 0; i < 100; i++) step(1'b0);
      f_start_i = 1'b1;
      step(1'b0);
      f_start_i = 1'b0;
      chk("ovr_flag", 32'(overrun_o), 32'd1);
      chk("ovr_cnt1", 32'(ovr_cnt_o), 32'd1);
      chk("ovr_busy", 32'(busy_o), 32'd1);
      finish_frame(1'b0, "ovr_frame");
      chk("ovr_no_abort", 32'(abort_o), 32'd0);
      clr_status_i = 1'b1;
      step(1'b0);
      clr_status_i = 1'b0;
      chk("clr_flag", 32'(overrun_o), 32'd0);
      chk("clr_cnt", 32'(ovr_cnt_o), 32'd0);

      // Wishbone takeover at sample 200
      start_frame();
      for (int i = 0; i < 3000 && acc_idx < 200; i++) step(1'b0);
      chk("abort_reach200", 32'(acc_idx), 32'd200);
      wb_mast_sel_i = 1'b1;
      wr_mark = wr_idx;
      step(1'b0);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_flag", 32'(abort_o), 32'd1);
      chk("abort_valid", 32'(smp_valid_o), 32'd0);
      chk("abort_res_ready", 32'(res_ready_o), 32'd0);
      chk("abort_wen", 32'(ram_wr_en_o), 32'd0);
      f_start_i = 1'b1;
      step(1'b0);
      f_start_i = 1'b0;
      chk("abort_drop_cnt", 32'(ovr_cnt_o), 32'd1);
      chk("abort_drop_busy", 32'(busy_o), 32'd0);
      for (int i = 0; i < 30; i++) step(1'b0);
      chk("abort_no_wr", 32'(wr_idx), 32'(wr_mark));
      chk("abort_no_done", 32'(done_cnt), 32'd0);

      // saturation, then clear racing a drop (Wishbone still owns the RAM)
      f_start_i = 1'b1;
      for (int i = 0; i < 300; i++) step(1'b0);
      f_start_i = 1'b0;
      chk("sat_cnt", 32'(ovr_cnt_o), 32'd255);
      f_start_i = 1'b1;
      clr_status_i = 1'b1;
      step(1'b0);
      f_start_i = 1'b0;
      clr_status_i = 1'b0;
      chk("race_cnt", 32'(ovr_cnt_o), 32'd1);
      chk("race_flag", 32'(overrun_o), 32'd1);
      chk("race_abort_clr", 32'(abort_o), 32'd0);
      wb_mast_sel_i = 1'b0;
      clr_status_i = 1'b1;
      step(1'b0);
      clr_status_i = 1'b0;

      // asynchronous reset at sample 50
      start_frame();
      for (int i = 0; i < 1000 && acc_idx < 50; i++) step(1'b0);
      chk("rst_reach50", 32'(acc_idx), 32'd50);
      #3 rst_n = 1'b0;
      #1 all_zero("async_rst");
      for (int i = 0; i < 3; i++) step(1'b0);
      chk("rst_no_wen", 32'(ram_wr_en_o), 32'd0);
      rst_n = 1'b1;
      step(1'b0);
      start_frame();
      finish_frame(1'b0, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
